// File: rtl/defines.sv
// rtl/defines.sv - shared constants and state type for the life controller
package defines;

  localparam int LIFE_INIT      = 3;
  localparam int LIFE_MAX       = 9;
  localparam int RESPAWN_FRAMES = 60;
  localparam int BLINK_FRAMES   = 8;

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    LOST_WAIT = 2'd1,
    RESPAWN   = 2'd2,
    GAME_OVER = 2'd3
  } life_state_t;

endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - saturating frame counter with terminal-count flag
module frame_timer #(
  parameter int TERMINAL = 60,
  parameter int W        = $clog2(TERMINAL + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         tick,
  output logic [W-1:0] count,
  output logic         done
);

  // done flags the tick that will bring count up to TERMINAL
  assign done = tick && (count == W'(TERMINAL - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (tick && (count != W'(TERMINAL))) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/life_ctrl.sv
// rtl/life_ctrl.sv - life counter FSM with respawn delay and indicator blink
module life_ctrl
  import defines::*;
#(
  parameter int LIFE_INIT      = defines::LIFE_INIT,
  parameter int LIFE_MAX       = defines::LIFE_MAX,
  parameter int RESPAWN_FRAMES = defines::RESPAWN_FRAMES,
  parameter int BLINK_FRAMES   = defines::BLINK_FRAMES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       ballLost,
  input  logic       bonusLife,
  input  logic       newGame,
  output logic [3:0] life,
  output logic       displayOn,
  output logic       respawn,
  output logic       gameOver
);

  localparam int CW = $clog2(RESPAWN_FRAMES + 1);
  localparam logic [3:0] LMAX  = 4'(LIFE_MAX);
  localparam logic [3:0] LINIT = 4'(LIFE_INIT);

  life_state_t   state;
  logic [CW-1:0] frameCnt;
  logic [CW-1:0] cnt_next;
  logic          tick;
  logic          clear;
  logic          done;
  logic [4:0]    sum_bonus;
  logic [4:0]    sum_net;
  logic [3:0]    play_life;
  logic [3:0]    inc_life;

  function automatic logic blink(input logic [CW-1:0] c);
    return ((int'(c) / BLINK_FRAMES) % 2) != 0;
  endfunction

  assign tick     = startOfFrame && (state == LOST_WAIT);
  assign clear    = newGame || (state != LOST_WAIT);
  assign cnt_next = tick ? frameCnt + 1'b1 : frameCnt;

  frame_timer #(
    .TERMINAL(RESPAWN_FRAMES),
    .W       (CW)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .clear(clear),
    .tick (tick),
    .count(frameCnt),
    .done (done)
  );

  // Bonus is added before the loss is subtracted so a coincident pair at LIFE_MAX nets to zero
  assign sum_bonus = {1'b0, life} + {4'b0, bonusLife};
  assign sum_net   = (ballLost && (sum_bonus != 5'd0)) ? sum_bonus - 5'd1 : sum_bonus;
  assign play_life = (sum_net > 5'(LIFE_MAX)) ? LMAX : sum_net[3:0];
  assign inc_life  = (life >= LMAX) ? LMAX : life + 4'd1;

  always_ff @(posedge clk) begin
    if (reset || newGame) begin
      state     <= PLAY;
      life      <= LINIT;
      displayOn <= 1'b1;
      respawn   <= 1'b0;
      gameOver  <= 1'b0;
    end else begin
      respawn <= 1'b0;
      case (state)
        PLAY: begin
          life <= play_life;
          if (ballLost) begin
            if (play_life != 4'd0) begin
              state     <= LOST_WAIT;
              displayOn <= blink('0);
            end else begin
              state     <= GAME_OVER;
              gameOver  <= 1'b1;
              displayOn <= 1'b1;
            end
          end
        end
        LOST_WAIT: begin
          if (bonusLife) life <= inc_life;
          if (done) begin
            state     <= RESPAWN;
            respawn   <= 1'b1;
            displayOn <= 1'b1;
          end else begin
            displayOn <= blink(cnt_next);
          end
        end
        RESPAWN: begin
          state <= PLAY;
        end
        GAME_OVER: begin
          gameOver <= 1'b1;
        end
        default: begin
          state <= PLAY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_life_ctrl.sv
// tb/tb_life_ctrl.sv - directed and randomized checks of life_ctrl against a behavioural model
module tb_life_ctrl;

  localparam int P_INIT  = 3;
  localparam int P_MAX   = 9;
  localparam int P_FRAMES = 4;
  localparam int P_BLINK = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       ballLost = 1'b0;
  logic       bonusLife = 1'b0;
  logic       newGame = 1'b0;
  logic [3:0] life;
  logic       displayOn;
  logic       respawn;
  logic       gameOver;

  int checks = 0;
  int failures = 0;
  int resp_seen = 0;

  // model: "mode" is a label for what the game is doing, not a copy of the RTL encoding
  string m_mode = "play";
  int    m_life = P_INIT;
  int    m_frames = 0;

  always #5 clk = ~clk;

  life_ctrl #(
    .LIFE_INIT     (P_INIT),
    .LIFE_MAX      (P_MAX),
    .RESPAWN_FRAMES(P_FRAMES),
    .BLINK_FRAMES  (P_BLINK)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .startOfFrame(startOfFrame),
    .ballLost    (ballLost),
    .bonusLife   (bonusLife),
    .newGame     (newGame),
    .life        (life),
    .displayOn   (displayOn),
    .respawn     (respawn),
    .gameOver    (gameOver)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input bit rst, input bit ng, input bit lost, input bit bon, input bit sof);
    int nl;
    if (rst || ng) begin
      m_mode = "play"; m_life = P_INIT; m_frames = 0;
    end else if (m_mode == "play") begin
      nl = m_life + (bon ? 1 : 0) - (lost ? 1 : 0);
      if (nl > P_MAX) nl = P_MAX;
      if (nl < 0) nl = 0;
      m_life = nl;
      if (lost) begin
        m_mode = (nl > 0) ? "wait" : "over";
        m_frames = 0;
      end
    end else if (m_mode == "wait") begin
      if (bon && m_life < P_MAX) m_life++;
      if (sof) begin
        m_frames++;
        if (m_frames == P_FRAMES) m_mode = "respawn";
      end
    end else if (m_mode == "respawn") begin
      m_mode = "play";
    end
  endtask

  task automatic step(input bit rst, input bit ng, input bit lost, input bit bon, input bit sof);
    reset = rst; newGame = ng; ballLost = lost; bonusLife = bon; startOfFrame = sof;
    @(posedge clk);
    model(rst, ng, lost, bon, sof);
    @(negedge clk);
    reset = 1'b0; newGame = 1'b0; ballLost = 1'b0; bonusLife = 1'b0; startOfFrame = 1'b0;
    if (respawn === 1'b1) resp_seen++;
    check("life", int'(life), m_life);
    check("displayOn", int'(displayOn),
          (m_mode == "wait") ? ((m_frames / P_BLINK) % 2) : 1);
    check("respawn", int'(respawn), (m_mode == "respawn") ? 1 : 0);
    check("gameOver", int'(gameOver), (m_mode == "over") ? 1 : 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic lose_and_recover();
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < P_FRAMES; i++) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
  endtask

  initial begin
    @(negedge clk);

    // reset then idle
    step(1, 0, 0, 0, 0);
    idle(10);
    check("rst_life", int'(life), 3);
    check("rst_display", int'(displayOn), 1);
    check("rst_respawn", int'(respawn), 0);
    check("rst_gameover", int'(gameOver), 0);

    // one loss, blink pattern, single respawn pulse
    resp_seen = 0;
    step(0, 0, 1, 0, 0);
    check("lost_life", int'(life), 2);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("blink_%0d", i), int'(displayOn), (i >= 2) ? 1 : 0);
      step(0, 0, 0, 0, 1);
    end
    check("respawn_pulse", int'(respawn), 1);
    step(0, 0, 0, 0, 0);
    check("respawn_once", resp_seen, 1);
    check("back_play_display", int'(displayOn), 1);

    // run out of lives
    step(0, 1, 0, 0, 0);
    for (int k = 0; k < 2; k++) lose_and_recover();
    step(0, 0, 1, 0, 0);
    check("over_life", int'(life), 0);
    check("over_flag", int'(gameOver), 1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    check("over_hold_life", int'(life), 0);
    check("over_hold_flag", int'(gameOver), 1);
    step(0, 1, 0, 0, 0);
    check("newgame_life", int'(life), 3);
    check("newgame_over", int'(gameOver), 0);

    // saturation, then coincident loss and bonus at the ceiling
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0);
    check("sat_life", int'(life), 9);
    step(0, 0, 1, 1, 0);
    check("coinc_life", int'(life), 9);
    check("coinc_wait_display", int'(displayOn), 0);
    check("coinc_wait_over", int'(gameOver), 0);
    for (int i = 0; i < P_FRAMES; i++) step(0, 0, 0, 0, 1);
    check("coinc_respawn", int'(respawn), 1);
    step(0, 0, 0, 0, 0);

    // reset mid-delay aborts without respawn
    resp_seen = 0;
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0);
    check("abort_life", int'(life), 3);
    check("abort_display", int'(displayOn), 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
    check("abort_no_respawn", resp_seen, 0);

    // newGame dominates a coincident loss
    lose_and_recover();
    check("pre_ng_life", int'(life), 2);
    resp_seen = 0;
    step(0, 1, 1, 0, 0);
    check("ng_life", int'(life), 3);
    check("ng_display", int'(displayOn), 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
    check("ng_not_wait", resp_seen, 0);
    check("ng_still_play", int'(displayOn), 1);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 600) == 0, ($urandom % 250) == 0, ($urandom % 12) == 0,
           ($urandom % 10) == 0, ($urandom % 3) == 0);
      check("life_bound", int'(life <= 4'(P_MAX)), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/life_ctrl.md
LIFE_CTRL -- requirements
Module: life_ctrl

Interface
REQ-001 The module SHALL have parameter LIFE_INIT, default defines::LIFE_INIT, giving the lives loaded at reset and at new game.
REQ-002 The module SHALL have parameter LIFE_MAX, default 9, giving the saturation ceiling for bonus lives.
REQ-003 The module SHALL have parameter RESPAWN_FRAMES, default 60, giving the frames spent in the post-loss delay.
REQ-004 The module SHALL have parameter BLINK_FRAMES, default 8, giving the frames per half-period of the life-indicator blink.
REQ-005 The module SHALL have port clk, input, 1 bit: the single system clock.
REQ-006 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The module SHALL have port startOfFrame, input, 1 bit: one-cycle pulse per video frame.
REQ-008 The module SHALL have port ballLost, input, 1 bit: one-cycle pulse when the ball leaves the field.
REQ-009 The module SHALL have port bonusLife, input, 1 bit: one-cycle pulse awarding one life.
REQ-010 The module SHALL have port newGame, input, 1 bit: one-cycle pulse restarting the game.
REQ-011 The module SHALL have port life, output, 4 bits: current life count, which feeds the indications block.
REQ-012 The module SHALL have port displayOn, output, 1 bit: gate for drawing the life indicator.
REQ-013 The module SHALL have port respawn, output, 1 bit: one-cycle ball relaunch request.
REQ-014 The module SHALL have port gameOver, output, 1 bit: high while in the GAME_OVER state.

Function
REQ-015 The module SHALL implement the FSM states PLAY, LOST_WAIT, RESPAWN and GAME_OVER, and all outputs SHALL be registered.
REQ-016 In PLAY, when ballLost=1 is sampled at cycle N, then at N+1 the module SHALL set life to life-1 and the state SHALL become LOST_WAIT if the new life is >0, or GAME_OVER if it is 0.
REQ-017 In PLAY or LOST_WAIT, bonusLife SHALL increment life, saturating at LIFE_MAX; in RESPAWN or GAME_OVER, bonusLife SHALL be ignored.
REQ-018 When ballLost and bonusLife occur in the same cycle in PLAY, the module SHALL add the net change, leaving life unchanged, and SHALL enter LOST_WAIT.
REQ-019 When life=LIFE_MAX and ballLost and bonusLife coincide, the result SHALL be LIFE_MAX (LIFE_MAX-1+1, no saturation loss).
REQ-020 In LOST_WAIT, RESPAWN and GAME_OVER, ballLost SHALL be ignored.
REQ-021 In LOST_WAIT, frameCnt SHALL increment on each startOfFrame.
REQ-022 On the startOfFrame that brings frameCnt to RESPAWN_FRAMES, the state SHALL move to RESPAWN on the next cycle.
REQ-023 frameCnt SHALL clear on entry to LOST_WAIT, and frameCnt SHALL NOT wrap.
REQ-024 RESPAWN SHALL last exactly one cycle with respawn=1, then the state SHALL return to PLAY; respawn SHALL be 0 in all other states.
REQ-025 displayOn SHALL be 1 in PLAY, RESPAWN and GAME_OVER.
REQ-026 In LOST_WAIT, displayOn SHALL be 1 iff (frameCnt / BLINK_FRAMES) is odd, so the indicator starts off.
REQ-027 gameOver SHALL be 1 iff the state is GAME_OVER; GAME_OVER SHALL hold until newGame or reset, with life=0.
REQ-028 newGame SHALL take priority over every other input in every state: at the next cycle the state SHALL be PLAY and life SHALL be LIFE_INIT, with frameCnt, respawn and gameOver cleared and displayOn=1.
REQ-029 startOfFrame SHALL be ignored outside LOST_WAIT.

Reset
REQ-030 When reset=1 is sampled on a clk edge, the module SHALL load state PLAY, life LIFE_INIT, frameCnt 0, displayOn 1, respawn 0 and gameOver 0, with reset dominating newGame and all other inputs.
REQ-031 A reset asserted mid-LOST_WAIT SHALL abort the delay with no respawn pulse.
REQ-032 life SHALL never exceed LIFE_MAX and SHALL never underflow below 0.

Structure
REQ-033 The defines package SHALL hold LIFE_INIT, LIFE_MAX, RESPAWN_FRAMES, BLINK_FRAMES and the life_state_t enum for the four states.
REQ-034 The frame counter with its terminal-count flag SHALL be the single sub-module frame_timer, with ports clk, reset, clear, tick, count and done.
REQ-035 life_ctrl SHALL contain only the FSM, the life arithmetic and the output registers.

Verification (bench parameters LIFE_INIT=3, LIFE_MAX=9, RESPAWN_FRAMES=4, BLINK_FRAMES=2)
REQ-036 The bench SHALL apply reset then idle for 10 cycles -> life=3, displayOn=1, respawn=0, gameOver=0.
REQ-037 The bench SHALL pulse ballLost, then apply 4 startOfFrame pulses -> life=2 next cycle, displayOn pattern 0,0,1,1 per frame, and respawn high for exactly 1 cycle after the 4th frame, then PLAY.
REQ-038 The bench SHALL apply 3 ballLost pulses, each after respawn -> life=0, gameOver=1; a further ballLost or bonusLife SHALL leave life=0; newGame -> life=3, gameOver=0.
REQ-039 The bench SHALL apply 8 bonusLife pulses -> life=9 (saturated); simultaneous ballLost+bonusLife -> life=9, state LOST_WAIT.
REQ-040 The bench SHALL assert reset after 2 frames of LOST_WAIT -> life=3, PLAY, and no respawn pulse ever appears.
REQ-041 The bench SHALL assert newGame and ballLost in the same cycle in PLAY with life=2 -> life=3, PLAY, not LOST_WAIT.
